pakout_ser: RTL and testbench
=============================

PAKOUT_SER -- requirements
Module: pakout_ser

Interface
REQ-001 The module SHALL have parameter PSZ, default `NS_PACKET_SIZE, meaning packet payload width in bits.
REQ-002 The module SHALL have parameter ASZ, default `NS_ADDRESS_SIZE, meaning src/dst address width.
REQ-003 The module SHALL have parameter DSZ, default `NS_DATA_SIZE, meaning message data width.
REQ-004 The module SHALL have parameter RSZ, default `NS_REDUN_SIZE, meaning redundancy field width.
REQ-005 The block SHALL use one clock; reset is synchronous and active-high.
REQ-006 The module SHALL have these ports (name, direction, width, meaning):
- i_clk  in  1  sole clock, all logic on posedge.
- reset  in  1  synchronous, active-high.
- i_msg_src  in  ASZ  message source address.
- i_msg_dst  in  ASZ  message destination address.
- i_msg_dat  in  DSZ  message data.
- i_msg_red  in  RSZ  message redundancy.
- i_msg_req  in  1  message request (4-phase).
- o_msg_ack  out  1  message acknowledge.
- o_pak_dat  out  PSZ  packet payload.
- o_pak_req  out  1  packet request (4-phase).
- i_pak_ack  in  1  packet acknowledge from downstream pakin sink.
- o_busy  out  1  high while a message is held or being serialized.

Function
REQ-007 Message word SHALL be MW = {red, dat, dst, src}, MSZ = 2*ASZ+DSZ+RSZ bits; NP = ceil(MSZ/PSZ) packets.
REQ-008 Packet k (k = 0..NP-1) SHALL carry MW[k*PSZ +: PSZ], LSB slice first; bits above MSZ in the last packet SHALL be zero.
REQ-009 States SHALL be IDLE, MSG_REL, PAK_WAIT, PAK_REQ, PAK_REL.
REQ-010 IDLE: on i_msg_req=1, latch all four message fields, set o_msg_ack=1, o_busy=1, go MSG_REL (ack high one cycle after req sampled).
REQ-011 MSG_REL: hold o_msg_ack=1 until i_msg_req=0; then o_msg_ack<=0, packet index<=0, go PAK_WAIT.
REQ-012 PAK_WAIT: if i_pak_ack=0, drive o_pak_dat=packet[index], set o_pak_req=1, go PAK_REQ; if i_pak_ack=1 (stale ack), stay, o_pak_req stays 0.
REQ-013 PAK_REQ: hold o_pak_req=1 and o_pak_dat stable until i_pak_ack=1; then o_pak_req<=0, go PAK_REL.
REQ-014 PAK_REL: wait i_pak_ack=0; then if index=NP-1 go IDLE with o_busy<=0, else index<=index+1, go PAK_WAIT.
REQ-015 o_pak_dat SHALL change only on the cycle o_pak_req rises; it SHALL not change while o_pak_req=1.
REQ-016 Latched message fields SHALL not change until return to IDLE; input field changes during serialization SHALL be ignored.
REQ-017 i_msg_req asserted while not IDLE SHALL not be acknowledged until IDLE is re-entered; the next message SHALL be accepted no earlier than the cycle after IDLE is entered.
REQ-018 i_pak_ack transitions in IDLE or MSG_REL SHALL have no effect.
REQ-019 Packet index counter SHALL be ceil(log2(NP+1)) bits and SHALL never exceed NP-1.
REQ-020 Minimum cost per packet with immediate ack response SHALL be 4 cycles (PAK_WAIT, PAK_REQ, PAK_REL, plus one ack edge).

Reset
REQ-021 While reset=1 at a clock edge: state<=IDLE, o_msg_ack=0, o_pak_req=0, o_pak_dat=0, o_busy=0, index=0, latched fields=0.
REQ-022 Reset mid-message SHALL abort the message; no remaining packets are sent after reset deasserts.
REQ-023 reset SHALL take priority over every other condition in the same cycle.

Verification (PSZ=ASZ=DSZ=RSZ=4, NP=4)
REQ-024 Send src=3, dst=1, dat=5, red=15 with prompt acks -> o_msg_ack pulses once; packets 0x3, 0x1, 0x5, 0xF in order; o_busy low after fourth ack falls.
REQ-025 Hold i_pak_ack=1 after the previous message completes, then send a new message -> o_pak_req stays 0 until i_pak_ack=0, then first packet is sent.
REQ-026 Delay i_pak_ack by 5 cycles per packet -> o_pak_req and o_pak_dat stable throughout each wait; no packet dropped or duplicated.
REQ-027 Assert reset after packet 1 is acked -> all outputs 0 next cycle; after release no packet is sent until a new i_msg_req.
REQ-028 Send 16 back-to-back messages with dat=0..15, dst cycling 1..1, src=3, red=15 -> 64 packets; every fourth-packet group decodes to src=3, dat incrementing by 1, red=15.
REQ-029 Change i_msg_dat mid-serialization -> emitted packets match the value latched at accept.

Source files
------------

// File: rtl/pakout_ser.sv
// rtl/pakout_ser.sv - message-to-packet serializer with 4-phase handshakes on both sides
`timescale 1ns/1ps

`ifndef NS_PACKET_SIZE
`define NS_PACKET_SIZE 4
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 4
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 4
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module pakout_ser #(
  parameter int PSZ = `NS_PACKET_SIZE,
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE,
  parameter int RSZ = `NS_REDUN_SIZE
) (
  input  logic           i_clk,
  input  logic           reset,
  input  logic [ASZ-1:0] i_msg_src,
  input  logic [ASZ-1:0] i_msg_dst,
  input  logic [DSZ-1:0] i_msg_dat,
  input  logic [RSZ-1:0] i_msg_red,
  input  logic           i_msg_req,
  output logic           o_msg_ack,
  output logic [PSZ-1:0] o_pak_dat,
  output logic           o_pak_req,
  input  logic           i_pak_ack,
  output logic           o_busy
);

  localparam int MSZ = 2*ASZ + DSZ + RSZ;
  localparam int NP  = (MSZ + PSZ - 1) / PSZ;
  localparam int MWP = NP * PSZ;
  localparam int IW  = $clog2(NP + 1);

  typedef enum logic [2:0] {IDLE, MSG_REL, PAK_WAIT, PAK_REQ, PAK_REL} state_t;

  state_t         state_q, state_d;
  logic [MWP-1:0] msg_q, msg_d;
  logic [IW-1:0]  idx_q, idx_d;
  logic           ack_q, ack_d;
  logic           req_q, req_d;
  logic [PSZ-1:0] dat_q, dat_d;
  logic           busy_q, busy_d;
  logic [PSZ-1:0] cur_pkt;

  // Message word is zero-padded to a whole number of packets; slice 0 goes first.
  always_comb begin
    cur_pkt = '0;
    for (int k = 0; k < NP; k++) begin
      if (idx_q == IW'(k)) cur_pkt = msg_q[k*PSZ +: PSZ];
    end
  end

  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    idx_d   = idx_q;
    ack_d   = ack_q;
    req_d   = req_q;
    dat_d   = dat_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (i_msg_req) begin
          msg_d   = MWP'({i_msg_red, i_msg_dat, i_msg_dst, i_msg_src});
          ack_d   = 1'b1;
          busy_d  = 1'b1;
          state_d = MSG_REL;
        end
      end
      MSG_REL: begin
        if (!i_msg_req) begin
          ack_d   = 1'b0;
          idx_d   = '0;
          state_d = PAK_WAIT;
        end
      end
      PAK_WAIT: begin
        // A stale ack from the previous packet must drop before a new request.
        if (!i_pak_ack) begin
          dat_d   = cur_pkt;
          req_d   = 1'b1;
          state_d = PAK_REQ;
        end
      end
      PAK_REQ: begin
        if (i_pak_ack) begin
          req_d   = 1'b0;
          state_d = PAK_REL;
        end
      end
      PAK_REL: begin
        if (!i_pak_ack) begin
          if (idx_q == IW'(NP - 1)) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = PAK_WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (reset) begin
      state_q <= IDLE;
      msg_q   <= '0;
      idx_q   <= '0;
      ack_q   <= 1'b0;
      req_q   <= 1'b0;
      dat_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      idx_q   <= idx_d;
      ack_q   <= ack_d;
      req_q   <= req_d;
      dat_q   <= dat_d;
      busy_q  <= busy_d;
    end
  end

  assign o_msg_ack = ack_q;
  assign o_pak_req = req_q;
  assign o_pak_dat = dat_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_pakout_ser.sv
// tb/tb_pakout_ser.sv - scoreboard bench for pakout_ser with PSZ=ASZ=DSZ=RSZ=4
`timescale 1ns/1ps

module tb_pakout_ser;

  logic       clk;
  logic       reset;
  logic [3:0] i_msg_src, i_msg_dst, i_msg_dat, i_msg_red;
  logic       i_msg_req;
  logic       o_msg_ack;
  logic [3:0] o_pak_dat;
  logic       o_pak_req;
  logic       i_pak_ack;
  logic       o_busy;

  logic       ack_sink, ack_hold;
  int         ack_dly;
  int         n_checks, n_errs;
  int         rx_cnt, ack_rise, glitch;
  logic       rst_at_edge;
  logic [3:0] exp_q[$];

  assign i_pak_ack = ack_sink | ack_hold;

  pakout_ser #(.PSZ(4), .ASZ(4), .DSZ(4), .RSZ(4)) dut (
    .i_clk(clk), .reset(reset),
    .i_msg_src(i_msg_src), .i_msg_dst(i_msg_dst), .i_msg_dat(i_msg_dat), .i_msg_red(i_msg_red),
    .i_msg_req(i_msg_req), .o_msg_ack(o_msg_ack),
    .o_pak_dat(o_pak_dat), .o_pak_req(o_pak_req), .i_pak_ack(i_pak_ack),
    .o_busy(o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Downstream pakin sink: every packet it accepts is compared against the scoreboard.
  initial begin
    logic [3:0] got;
    logic       bad;
    int         n;
    ack_sink = 1'b0;
    forever begin
      @(negedge clk);
      if (o_pak_req && !i_pak_ack) begin
        got = o_pak_dat;
        bad = 1'b0;
        for (int c = 0; c < ack_dly; c++) begin
          @(negedge clk);
          if (!o_pak_req || o_pak_dat !== got) bad = 1'b1;
        end
        if (exp_q.size() == 0) check("unexpected_pkt", 32'(got), 32'hFFFF_FFFF);
        else check("pkt", 32'(got), 32'(exp_q.pop_front()));
        if (ack_dly > 0) check("pkt_stable", 32'(bad), 32'd0);
        ack_sink = 1'b1;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (o_pak_req && n < 100);
        if (o_pak_req) check("req_fall_timeout", 32'd1, 32'd0);
        ack_sink = 1'b0;
        rx_cnt++;
      end
    end
  end

  initial forever begin
    @(posedge clk);
    rst_at_edge = reset;
  end

  // o_pak_dat may only move on the cycle o_pak_req rises (or under reset).
  initial begin
    logic [3:0] prev_dat;
    logic       prev_req, prev_ack;
    prev_dat = '0; prev_req = 1'b0; prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (o_pak_dat !== prev_dat && !(o_pak_req && !prev_req) && !rst_at_edge) glitch++;
      if (o_msg_ack && !prev_ack) ack_rise++;
      prev_dat = o_pak_dat;
      prev_req = o_pak_req;
      prev_ack = o_msg_ack;
    end
  end

  task automatic send_msg(input logic [3:0] src, input logic [3:0] dst,
                          input logic [3:0] dat, input logic [3:0] red);
    logic [15:0] mw;
    int          a0, n;
    mw = {red, dat, dst, src};
    for (int k = 0; k < 4; k++) exp_q.push_back(mw[k*4 +: 4]);
    a0 = ack_rise;
    i_msg_src = src; i_msg_dst = dst; i_msg_dat = dat; i_msg_red = red;
    i_msg_req = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!o_msg_ack && n < 1000);
    if (!o_msg_ack) check("msg_ack_timeout", 32'd1, 32'd0);
    i_msg_req = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (o_msg_ack && n < 100);
    if (o_msg_ack) check("msg_ack_fall_timeout", 32'd1, 32'd0);
    check("msg_ack_pulses", 32'(ack_rise - a0), 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((o_busy || exp_q.size() != 0 || ack_sink) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    int   base, n;
    logic req_seen;
    n_checks = 0; n_errs = 0; rx_cnt = 0; ack_rise = 0; glitch = 0;
    ack_hold = 1'b0; ack_dly = 0;
    i_msg_src = '0; i_msg_dst = '0; i_msg_dat = '0; i_msg_red = '0; i_msg_req = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_msg_ack", 32'(o_msg_ack), 32'd0);
    check("rst_pak_req", 32'(o_pak_req), 32'd0);
    check("rst_pak_dat", 32'(o_pak_dat), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    send_msg(4'd3, 4'd1, 4'd5, 4'd15);
    check("busy_serializing", 32'(o_busy), 32'd1);
    wait_idle();

    ack_hold = 1'b1;
    @(negedge clk);
    send_msg(4'd2, 4'd9, 4'd4, 4'd6);
    req_seen = 1'b0;
    repeat (10) begin @(negedge clk); if (o_pak_req) req_seen = 1'b1; end
    check("stale_ack_blocks_req", 32'(req_seen), 32'd0);
    ack_hold = 1'b0;
    wait_idle();

    ack_dly = 5;
    send_msg(4'd10, 4'd12, 4'd7, 4'd1);
    wait_idle();
    ack_dly = 0;

    send_msg(4'd6, 4'd5, 4'd9, 4'd3);
    i_msg_dat = 4'hE; i_msg_src = 4'h0; i_msg_red = 4'h8;
    wait_idle();

    base = rx_cnt;
    send_msg(4'd1, 4'd2, 4'd3, 4'd4);
    n = 0;
    while (rx_cnt < base + 2 && n < 500) begin @(negedge clk); n++; end
    if (n >= 500) check("rx2_timeout", 32'd1, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_msg_ack", 32'(o_msg_ack), 32'd0);
    check("midrst_pak_req", 32'(o_pak_req), 32'd0);
    check("midrst_pak_dat", 32'(o_pak_dat), 32'd0);
    check("midrst_busy", 32'(o_busy), 32'd0);
    reset = 1'b0;
    exp_q.delete();
    base = rx_cnt;
    req_seen = 1'b0;
    repeat (20) begin @(negedge clk); if (o_pak_req) req_seen = 1'b1; end
    check("no_req_after_rst", 32'(req_seen), 32'd0);
    check("no_pkt_after_rst", 32'(rx_cnt - base), 32'd0);
    send_msg(4'd3, 4'd1, 4'd5, 4'd15);
    wait_idle();

    base = rx_cnt;
    for (int d = 0; d < 16; d++) send_msg(4'd3, 4'd1, 4'(d), 4'd15);
    wait_idle();
    check("b2b_pkt_count", 32'(rx_cnt - base), 32'd64);
    check("pak_dat_glitch", 32'(glitch), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
